ahb_flash_spi_engine: RTL and testbench
=======================================

# ahb_flash_spi_engine

AHB-Lite slave that drives a serial flash with a hardware SPI byte shifter in place of per-bit register writes. It occupies the same bus slot as the flash writer, downstream of the UART-to-AHB master. Each bus write to TXDATA shifts one byte out on SIO0 and captures one byte from SIO1. This cuts UART traffic per flash byte from 24 bus writes to 1.

## Interface

Parameters:
- CLK_DIV, default 2: SCK half-period in HCLK cycles; legal range 1–255.
- MAGIC, default 32'h5350_4945: constant returned by the ID register.

Ports:
- HCLK  in  1  bus clock; the block's only clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL, HREADY  in  1 each  AHB-Lite slave select / bus ready.
- HTRANS  in  2  transfer type; bit1 set = NONSEQ/SEQ.
- HWRITE  in  1  write strobe.
- HSIZE  in  3  ignored; every access is treated as a word.
- HADDR  in  32  only bits [4:2] are decoded.
- HWDATA  in  32  write data.
- HREADYOUT  out  1  low = wait state.
- HRDATA  out  32  read data.
- fm_sck, fm_ce_n  out  1 each  flash clock / chip select.
- fm_din  in  4  flash data in; only bit 1 (MISO) is used.
- fm_dout, fm_douten  out  4 each  bit 0 = MOSI; other bits drive 0.

## Operation

Register map (word offsets):
- 0x00 KEY (W): writing 0xA5A85501 sets `en`; writing any other value clears it. Read returns {31'b0, en}.
- 0x04 CS (RW): bit0 drives fm_ce_n. Reset value 1.
- 0x08 TXDATA (W): bits[7:0] start a transfer. Ignored when `en`=0. Reads 0.
- 0x0C RXDATA (R): last captured byte, zero-extended.
- 0x10 STATUS (R): bit0 = busy, bit1 = en.
- 0x14 ID (R): MAGIC.
- Unmapped offsets: read 0, writes ignored, no error response.

Shifter FSM:
- States IDLE, LOW, HIGH.
- IDLE→LOW: on an accepted TXDATA write with en=1. Load the shift register and set the bit counter to 7.
- LOW: fm_sck=0, fm_dout[0]=tx[7]. After CLK_DIV cycles → HIGH.
- HIGH: fm_sck=1. On entry, sample fm_din[1] into rx LSB. After CLK_DIV cycles: shift tx left; if bit counter=0 → IDLE, else decrement → LOW.
- Byte order: MSB first, SPI mode 0.

Output and bus rules:
- fm_douten = {3'b0, en}. fm_dout[3:1] = 0.
- An access to TXDATA, CS or RXDATA while busy stalls: HREADYOUT=0 until the FSM returns to IDLE, then the access completes. CS therefore never changes mid-byte.
- Access to KEY, STATUS or ID never stalls.
- Clearing en while busy takes effect immediately and aborts the transfer: FSM → IDLE, SCK → 0, RXDATA holds its previous value.

## Timing

- Address phase is registered when HSEL & HREADY & HTRANS[1]. Write data is taken in the following data phase.
- Transfer start: FSM leaves IDLE on the cycle after the TXDATA data phase completes.
- busy: high for exactly 16·CLK_DIV cycles. With CLK_DIV=2 that is 32 cycles; RXDATA is valid on the cycle busy falls.
- Reads return data in the data phase with zero wait states unless stalled.
- Reset values: HREADYOUT=1, HRDATA=0, fm_sck=0, fm_ce_n=1, fm_dout=0, fm_douten=0, en=0, RXDATA=0, FSM=IDLE.
- Reset asserted mid-transfer returns all outputs to their reset values asynchronously.

## Structure

- Shared package holds:
  - register offsets (KEY_OFF … ID_OFF),
  - KEY_VALUE 32'hA5A85501,
  - the FSM state encoding.
- One sub-module, `spi_byte_shifter`: the FSM, clock divider, bit counter and shift registers, with a start/busy/done handshake. The top level holds only the AHB decode and the registers.

## Test plan

- After reset, read ID → 0x53504945; read STATUS → 0; pins at reset values.
- Write TXDATA=0x9F with en=0 → no SCK edges; STATUS.busy stays 0.
- Write KEY=0xA5A85501, CS=0, TXDATA=0x9F, then three TXDATA=0x00 writes, each followed by a RXDATA read, against the SST26WF080B model → reads return 0xBF, 0x26, 0x58. Each byte produces 8 SCK pulses, 32 cycles busy.
- TXDATA write immediately followed by a CS=1 write → HREADYOUT low for the remainder of the 32 cycles. fm_ce_n rises only after the 8th SCK falling edge.
- Write KEY=0 at bit 3 of a transfer → SCK returns to 0 next cycle, busy=0, RXDATA unchanged, douten=0.
- Assert HRESETn low mid-byte → fm_ce_n=1, fm_sck=0, busy=0 without waiting for a clock edge.

Source files
------------

// File: rtl/ahb_flash_spi_engine_pkg.sv
// Shared definitions for the AHB flash SPI engine: register offsets, unlock key, shifter states.
package ahb_flash_spi_engine_pkg;

    localparam logic [2:0] KEY_OFF    = 3'd0;
    localparam logic [2:0] CS_OFF     = 3'd1;
    localparam logic [2:0] TX_OFF     = 3'd2;
    localparam logic [2:0] RX_OFF     = 3'd3;
    localparam logic [2:0] STATUS_OFF = 3'd4;
    localparam logic [2:0] ID_OFF     = 3'd5;

    localparam logic [31:0] KEY_VALUE = 32'hA5A8_5501;

    // LOW and HIGH differ in one bit so the decoded SCK stays clean between them.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOW  = 2'b01,
        ST_HIGH = 2'b11
    } spi_state_e;

endpackage

// File: rtl/ahb_flash_spi_engine_spi_byte_shifter.sv
// SPI mode-0 byte shifter: MSB first, SCK half-period of CLK_DIV clocks, start/busy/done handshake.
module spi_byte_shifter
    import ahb_flash_spi_engine_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    spi_state_e state_q, state_d;
    logic [7:0] div_q;
    logic [2:0] bit_q;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic       div_end;

    assign div_end = (div_q == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOW;
            ST_LOW:  if (div_end) state_d = ST_HIGH;
            ST_HIGH: begin
                if (div_end) begin
                    if (bit_q == 3'd0) begin
                        state_d = ST_IDLE;
                        done    = 1'b1;
                    end else begin
                        state_d = ST_LOW;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            done    = 1'b0;
        end
    end

    // Divider reloads on every state change so each SCK phase lasts exactly CLK_DIV clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 8'd0;
            bit_q <= 3'd0;
        end else begin
            if (state_q == ST_IDLE || state_d != state_q) div_q <= DIV_LAST;
            else                                          div_q <= div_q - 8'd1;
            if (state_q == ST_IDLE)                             bit_q <= 3'd7;
            else if (state_q == ST_HIGH && state_d == ST_LOW)   bit_q <= bit_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && start)        tx_sr <= tx_byte;
        else if (state_q == ST_HIGH && div_end) tx_sr <= {tx_sr[6:0], 1'b0};
        if (state_q == ST_LOW && state_d == ST_HIGH) rx_sr <= {rx_sr[6:0], miso};
    end

    assign sck     = (state_q == ST_HIGH);
    assign busy    = (state_q != ST_IDLE);
    assign mosi    = busy & tx_sr[7];
    assign rx_byte = rx_sr;

endmodule

// File: rtl/ahb_flash_spi_engine.sv
// AHB-Lite slave wrapping a hardware SPI byte shifter for serial-flash access over one bus write per byte.
module ahb_flash_spi_engine
    import ahb_flash_spi_engine_pkg::*;
#(
    parameter int          CLK_DIV = 2,
    parameter logic [31:0] MAGIC   = 32'h5350_4945
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        fm_sck,
    output logic        fm_ce_n,
    input  logic [3:0]  fm_din,
    output logic [3:0]  fm_dout,
    output logic [3:0]  fm_douten
);

    logic       vld_p1;
    logic       write_p1;
    logic [2:0] addr_p1;
    logic       en;
    logic       cs_q;
    logic [7:0] rxdata;

    logic       busy, done, mosi, sck;
    logic [7:0] rx_byte;
    logic       stall_reg, wr_fire, key_wr, start, abort;
    logic [31:0] rdata;
    logic       unused_bits;

    assign unused_bits = ^{HSIZE, HADDR[31:5], HADDR[1:0], fm_din[3:2], fm_din[0]};

    // Address phase -> data phase boundary
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            vld_p1   <= 1'b0;
            write_p1 <= 1'b0;
            addr_p1  <= 3'd0;
        end else if (HREADY) begin
            vld_p1   <= HSEL & HTRANS[1];
            write_p1 <= HWRITE;
            addr_p1  <= HADDR[4:2];
        end
    end

    // CS, TXDATA and RXDATA wait for the byte in flight so CS can never move mid-byte.
    assign stall_reg = (addr_p1 == CS_OFF) || (addr_p1 == TX_OFF) || (addr_p1 == RX_OFF);
    assign HREADYOUT = !(vld_p1 && stall_reg && busy);
    assign wr_fire   = vld_p1 && write_p1 && HREADYOUT;
    assign key_wr    = wr_fire && (addr_p1 == KEY_OFF);
    assign start     = wr_fire && (addr_p1 == TX_OFF) && en;
    assign abort     = key_wr && (HWDATA != KEY_VALUE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            en     <= 1'b0;
            cs_q   <= 1'b1;
            rxdata <= 8'd0;
        end else begin
            if (key_wr)                           en     <= (HWDATA == KEY_VALUE);
            if (wr_fire && (addr_p1 == CS_OFF))   cs_q   <= HWDATA[0];
            if (done)                             rxdata <= rx_byte;
        end
    end

    always_comb begin
        rdata  = 32'd0;
        HRDATA = 32'd0;
        case (addr_p1)
            KEY_OFF:    rdata = {31'd0, en};
            CS_OFF:     rdata = {31'd0, cs_q};
            RX_OFF:     rdata = {24'd0, rxdata};
            STATUS_OFF: rdata = {30'd0, en, busy};
            ID_OFF:     rdata = MAGIC;
            default:    rdata = 32'd0;
        endcase
        if (vld_p1 && !write_p1) HRDATA = rdata;
    end

    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .start   (start),
        .abort   (abort),
        .tx_byte (HWDATA[7:0]),
        .miso    (fm_din[1]),
        .sck     (sck),
        .mosi    (mosi),
        .busy    (busy),
        .done    (done),
        .rx_byte (rx_byte)
    );

    assign fm_sck    = sck;
    assign fm_ce_n   = cs_q;
    assign fm_dout   = {3'b000, mosi};
    assign fm_douten = {3'b000, en};

endmodule

// File: tb/tb_ahb_flash_spi_engine.sv
// Self-checking bench for ahb_flash_spi_engine with a byte-level serial-flash responder.
module tb_ahb_flash_spi_engine;

    localparam int          CLK_DIV = 2;
    localparam logic [31:0] MAGIC   = 32'h5350_4945;
    localparam logic [31:0] KEY     = 32'hA5A8_5501;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL, HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HREADYOUT;
    logic        fm_sck, fm_ce_n;
    logic [3:0]  fm_din, fm_dout, fm_douten;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_last_rx = 8'h00;

    always #5 HCLK = ~HCLK;

    ahb_flash_spi_engine #(.CLK_DIV(CLK_DIV), .MAGIC(MAGIC)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADYOUT),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HADDR(HADDR),
        .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
        .fm_sck(fm_sck), .fm_ce_n(fm_ce_n), .fm_din(fm_din),
        .fm_dout(fm_dout), .fm_douten(fm_douten)
    );

    // Serial flash responder: mode 0, shifts MISO on SCK falling, samples MOSI on SCK rising.
    logic [7:0] flash_out = 8'hFF;
    logic [7:0] in_sr = 8'h00;
    logic [7:0] last_mosi = 8'h00;
    logic [7:0] resp_q[$];
    int  nbits = 0;
    int  sck_rises = 0;
    int  sck_falls = 0;
    bit  jedec_mode = 1'b0;

    assign fm_din = {2'b00, flash_out[7], 1'b0};

    always @(negedge fm_ce_n) begin
        if (resp_q.size() > 0) flash_out = resp_q.pop_front();
        else                   flash_out = 8'hFF;
        nbits = 0;
    end

    always @(posedge fm_ce_n) begin
        nbits = 0;
        resp_q.delete();
    end

    always @(posedge fm_sck) begin
        sck_rises++;
        if (!fm_ce_n) begin
            in_sr = {in_sr[6:0], fm_dout[0]};
            nbits++;
            if (nbits == 8) begin
                nbits = 0;
                last_mosi = in_sr;
                if (jedec_mode && in_sr == 8'h9F) begin
                    resp_q.push_back(8'hBF);
                    resp_q.push_back(8'h26);
                    resp_q.push_back(8'h58);
                end
            end
        end
    end

    always @(negedge fm_sck) begin
        sck_falls++;
        if (!fm_ce_n) begin
            if (nbits == 0) begin
                if (resp_q.size() > 0) flash_out = resp_q.pop_front();
                else                   flash_out = 8'hFF;
            end else begin
                flash_out = flash_out << 1;
            end
        end
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge HCLK);
        while (!HREADYOUT && n < 1000) begin
            n++;
            @(negedge HCLK);
        end
        if (!HREADYOUT) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: HREADYOUT stuck at 0 after %0d cycles", tag, n);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge HCLK);
        #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        wait_ready("bus_write");
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK);
        #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        wait_ready("bus_read");
        d = HRDATA;
        @(posedge HCLK);
        #1;
    endtask

    task automatic wait_rises(input int target);
        int n = 0;
        while (sck_rises < target && n < 1000) begin
            n++;
            @(negedge HCLK);
        end
        if (sck_rises < target) begin
            checks++;
            failures++;
            $display("FAIL wait_sck timeout: rises=%0d required=%0d", sck_rises, target);
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        checks++;
        if ({fm_sck, fm_ce_n, fm_dout, fm_douten, HREADYOUT, HRDATA} !== {1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL reset_pins: sck=%b ce_n=%b dout=%h douten=%h rdy=%b rdata=%h required 0 1 0 0 1 0",
                     fm_sck, fm_ce_n, fm_dout, fm_douten, HREADYOUT, HRDATA);
        end
        HRESETn = 1'b1;
        bus_read(32'h14, rd);
        checks++;
        if (rd !== MAGIC) begin failures++; $display("FAIL reset_id: got %h required %h", rd, MAGIC); end
        bus_read(32'h10, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL reset_status: got %h required 0", rd); end
        bus_read(32'h04, rd);
        checks++;
        if (rd !== 32'h1) begin failures++; $display("FAIL reset_cs: got %h required 1", rd); end
        bus_read(32'h0C, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL reset_rxdata: got %h required 0", rd); end
        bus_read(32'h1C, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL unmapped_read: got %h required 0", rd); end
    endtask

    task automatic test_tx_disabled;
        logic [31:0] rd;
        int base = sck_rises;
        bus_write(32'h08, 32'h9F);
        repeat (40) @(negedge HCLK);
        checks++;
        if (sck_rises !== base) begin failures++; $display("FAIL tx_disabled_sck: rises=%0d required %0d", sck_rises - base, 0); end
        bus_read(32'h10, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL tx_disabled_status: got %h required 0", rd); end
    endtask

    task automatic test_jedec_id;
        logic [31:0] rd;
        logic [7:0]  exp_id[3];
        int base;
        exp_id[0] = 8'hBF; exp_id[1] = 8'h26; exp_id[2] = 8'h58;
        jedec_mode = 1'b1;
        bus_write(32'h00, KEY);
        bus_read(32'h10, rd);
        checks++;
        if (rd !== 32'h2) begin failures++; $display("FAIL enable_status: got %h required 2", rd); end
        checks++;
        if (fm_douten !== 4'h1) begin failures++; $display("FAIL enable_douten: got %h required 1", fm_douten); end
        bus_write(32'h04, 32'h0);
        base = sck_rises;
        bus_write(32'h08, 32'h9F);
        bus_read(32'h0C, rd);
        checks++;
        if (sck_rises - base !== 8) begin failures++; $display("FAIL jedec_cmd_pulses: got %0d required 8", sck_rises - base); end
        for (int i = 0; i < 3; i++) begin
            base = sck_rises;
            bus_write(32'h08, 32'h00);
            bus_read(32'h0C, rd);
            checks++;
            if (rd !== {24'h0, exp_id[i]}) begin failures++; $display("FAIL jedec_byte%0d: got %h required %h", i, rd, exp_id[i]); end
            checks++;
            if (sck_rises - base !== 8) begin failures++; $display("FAIL jedec_pulses%0d: got %0d required 8", i, sck_rises - base); end
        end
        exp_last_rx = exp_id[2];
        bus_write(32'h04, 32'h1);
        jedec_mode = 1'b0;
    endtask

    task automatic test_random_bytes;
        logic [31:0] rd;
        logic [7:0]  t, r;
        int base;
        for (int i = 0; i < 6; i++) begin
            t = 8'($urandom);
            r = 8'($urandom);
            resp_q.push_back(r);
            bus_write(32'h04, 32'h0);
            base = sck_rises;
            bus_write(32'h08, {24'($urandom), t});
            bus_read(32'h0C, rd);
            checks++;
            if (rd !== {24'h0, r}) begin failures++; $display("FAIL rand_rx%0d: got %h required %h", i, rd, r); end
            checks++;
            if (last_mosi !== t) begin failures++; $display("FAIL rand_mosi%0d: got %h required %h", i, last_mosi, t); end
            checks++;
            if (sck_rises - base !== 8) begin failures++; $display("FAIL rand_pulses%0d: got %0d required 8", i, sck_rises - base); end
            exp_last_rx = r;
            bus_write(32'h04, 32'h1);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        logic [7:0]  t, r;
        int stall = 0;
        int fbase;
        t = 8'($urandom);
        r = 8'($urandom);
        resp_q.push_back(r);
        bus_write(32'h04, 32'h0);
        fbase = sck_falls;
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h08;
        @(posedge HCLK);
        #1;
        HADDR = 32'h04; HWDATA = {24'h0, t};
        @(posedge HCLK);
        #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h1;
        @(negedge HCLK);
        while (!HREADYOUT && stall < 1000) begin
            stall++;
            @(negedge HCLK);
        end
        checks++;
        if (stall !== 16 * CLK_DIV) begin failures++; $display("FAIL b2b_stall: got %0d cycles required %0d", stall, 16 * CLK_DIV); end
        checks++;
        if (fm_ce_n !== 1'b0 || sck_falls - fbase !== 8) begin
            failures++;
            $display("FAIL b2b_ce_early: ce_n=%b falls=%0d required ce_n=0 falls=8", fm_ce_n, sck_falls - fbase);
        end
        @(posedge HCLK);
        @(negedge HCLK);
        checks++;
        if (fm_ce_n !== 1'b1) begin failures++; $display("FAIL b2b_ce_rise: got %b required 1", fm_ce_n); end
        bus_read(32'h0C, rd);
        checks++;
        if (rd !== {24'h0, r}) begin failures++; $display("FAIL b2b_rx: got %h required %h", rd, r); end
        exp_last_rx = r;
    endtask

    task automatic test_abort;
        logic [31:0] rd;
        int base;
        resp_q.push_back(8'($urandom));
        bus_write(32'h04, 32'h0);
        base = sck_rises;
        bus_write(32'h08, 32'($urandom));
        wait_rises(base + 3);
        bus_write(32'h00, 32'h0);
        @(negedge HCLK);
        checks++;
        if ({fm_sck, fm_dout, fm_douten} !== {1'b0, 4'h0, 4'h0}) begin
            failures++;
            $display("FAIL abort_pins: sck=%b dout=%h douten=%h required 0 0 0", fm_sck, fm_dout, fm_douten);
        end
        bus_read(32'h10, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL abort_status: got %h required 0", rd); end
        bus_read(32'h0C, rd);
        checks++;
        if (rd !== {24'h0, exp_last_rx}) begin failures++; $display("FAIL abort_rx_hold: got %h required %h", rd, exp_last_rx); end
        bus_write(32'h04, 32'h1);
    endtask

    task automatic test_reset_mid_byte;
        logic [31:0] rd;
        int base;
        bus_write(32'h00, KEY);
        bus_write(32'h04, 32'h0);
        base = sck_rises;
        bus_write(32'h08, 32'h0000_00FF);
        wait_rises(base + 3);
        @(negedge HCLK);
        #1;
        HRESETn = 1'b0;
        #1;
        checks++;
        if ({fm_sck, fm_ce_n, fm_dout, fm_douten, HREADYOUT} !== {1'b0, 1'b1, 4'h0, 4'h0, 1'b1}) begin
            failures++;
            $display("FAIL async_reset_pins: sck=%b ce_n=%b dout=%h douten=%h rdy=%b required 0 1 0 0 1",
                     fm_sck, fm_ce_n, fm_dout, fm_douten, HREADYOUT);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        bus_read(32'h10, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL async_reset_status: got %h required 0", rd); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        HRESETn = 1'b0;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010;
        HADDR = 32'h0; HWDATA = 32'h0;
        test_reset;
        test_tx_disabled;
        test_jedec_id;
        test_random_bytes;
        test_back_to_back;
        test_abort;
        test_reset_mid_byte;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
